gerenciador_jogada: RTL

//  Move controller directly upstream of the player-toggle flip-flop.

---
 rtl/gerenciador_jogada_if.sv | 27 ++
 rtl/gerenciador_jogada.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/gerenciador_jogada_if.sv
// Signal bundle between the move controller and its surrounding game logic.
// The slave side belongs to gerenciador_jogada; the master side drives moves.
interface gerenciador_jogada_if;
  logic        iniciar;
  logic        jogar;
  logic [3:0]  posicao;
  logic        jogador;
  logic        troca_jogador;
  logic        limpa_jogador;
  logic [17:0] tabuleiro;
  logic        jogada_invalida;
  logic [1:0]  vencedor;
  logic        fim_jogo;
  logic [2:0]  db_estado;

  modport master (
    output iniciar, jogar, posicao, jogador,
    input  troca_jogador, limpa_jogador, tabuleiro, jogada_invalida,
           vencedor, fim_jogo, db_estado
  );

  modport slave (
    input  iniciar, jogar, posicao, jogador,
    output troca_jogador, limpa_jogador, tabuleiro, jogada_invalida,
           vencedor, fim_jogo, db_estado
  );
endinterface

// File: rtl/gerenciador_jogada.sv
// Tic-tac-toe move controller: validates a cell, writes the current mark,
// detects win/draw and pulses the player-toggle flip-flop.
module gerenciador_jogada #(
  parameter int TIMEOUT_CICLOS = 100
) (
  input  logic               clk,
  input  logic               reset,
  gerenciador_jogada_if.slave bus
);

  typedef enum logic [2:0] {
    INICIAL  = 3'b000,
    ESPERA   = 3'b001,
    VERIFICA = 3'b010,
    REGISTRA = 3'b011,
    AVALIA   = 3'b100,
    TROCA    = 3'b101,
    FIM      = 3'b110
  } estado_t;

  localparam int            CW      = $clog2(TIMEOUT_CICLOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CICLOS - 1);

  estado_t       state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [17:0]   tabuleiro_q, tabuleiro_d;
  logic [1:0]    vencedor_q, vencedor_d;
  logic [3:0]    posicao_q, posicao_d;
  logic          jogar_q;

  logic [1:0] celula [9];
  logic [8:0] ocupada;
  logic [7:0] linha_x, linha_o;
  logic       borda, cheio, invalida;
  logic [3:0] indice;

  function automatic logic trio(input logic [1:0] a, b, c, m);
    return (a == m) && (b == m) && (c == m);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_celula
      assign celula[gi]  = tabuleiro_q[2*gi +: 2];
      assign ocupada[gi] = |celula[gi];
    end
    // Lines 0..2 are rows, 3..5 are columns, 6..7 are the diagonals.
    for (gi = 0; gi < 3; gi++) begin : g_linhas
      assign linha_x[gi]   = trio(celula[3*gi], celula[3*gi+1], celula[3*gi+2], 2'b01);
      assign linha_o[gi]   = trio(celula[3*gi], celula[3*gi+1], celula[3*gi+2], 2'b10);
      assign linha_x[3+gi] = trio(celula[gi], celula[gi+3], celula[gi+6], 2'b01);
      assign linha_o[3+gi] = trio(celula[gi], celula[gi+3], celula[gi+6], 2'b10);
    end
  endgenerate

  assign linha_x[6] = trio(celula[0], celula[4], celula[8], 2'b01);
  assign linha_o[6] = trio(celula[0], celula[4], celula[8], 2'b10);
  assign linha_x[7] = trio(celula[2], celula[4], celula[6], 2'b01);
  assign linha_o[7] = trio(celula[2], celula[4], celula[6], 2'b10);

  assign cheio    = &ocupada;
  assign borda    = bus.jogar & ~jogar_q;
  assign indice   = (posicao_q > 4'd8) ? 4'd0 : posicao_q;
  assign invalida = (posicao_q > 4'd8) || (celula[indice] != 2'b00);

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    tabuleiro_d = tabuleiro_q;
    vencedor_d  = vencedor_q;
    posicao_d   = posicao_q;
    if (bus.iniciar && state_q != INICIAL) begin
      state_d = INICIAL;
    end else begin
      unique case (state_q)
        INICIAL: begin
          tabuleiro_d = '0;
          vencedor_d  = 2'b00;
          counter_d   = '0;
          if (bus.iniciar) state_d = ESPERA;
        end
        ESPERA: begin
          // Saturates at the timeout value so the count can never wrap.
          if (counter_q != CNT_MAX) counter_d = counter_q + 1'b1;
          if (borda) begin
            state_d   = VERIFICA;
            posicao_d = bus.posicao;
          end else if (counter_q == CNT_MAX) begin
            state_d = TROCA;
          end
        end
        VERIFICA: state_d = invalida ? ESPERA : REGISTRA;
        REGISTRA: begin
          for (int k = 0; k < 9; k++) begin
            if (posicao_q == 4'(k)) tabuleiro_d[2*k +: 2] = bus.jogador ? 2'b10 : 2'b01;
          end
          state_d = AVALIA;
        end
        AVALIA: begin
          if (|linha_x) begin
            vencedor_d = 2'b01;
            state_d    = FIM;
          end else if (|linha_o) begin
            vencedor_d = 2'b10;
            state_d    = FIM;
          end else if (cheio) begin
            vencedor_d = 2'b11;
            state_d    = FIM;
          end else begin
            state_d = TROCA;
          end
        end
        TROCA: begin
          counter_d = '0;
          state_d   = ESPERA;
        end
        FIM:     state_d = FIM;
        default: state_d = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INICIAL;
      counter_q   <= '0;
      tabuleiro_q <= '0;
      vencedor_q  <= 2'b00;
      posicao_q   <= '0;
      jogar_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      tabuleiro_q <= tabuleiro_d;
      vencedor_q  <= vencedor_d;
      posicao_q   <= posicao_d;
      jogar_q     <= bus.jogar;
    end
  end

  // Outputs decode only registered state and data, never the live inputs.
  assign bus.troca_jogador   = (state_q == TROCA);
  assign bus.limpa_jogador   = (state_q == INICIAL);
  assign bus.jogada_invalida = (state_q == VERIFICA) && invalida;
  assign bus.fim_jogo        = (state_q == FIM);
  assign bus.tabuleiro       = tabuleiro_q;
  assign bus.vencedor        = vencedor_q;
  assign bus.db_estado       = state_q;

endmodule
